// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead byte FIFO onto an 8N1 serial line.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | line high; pops the head byte when tx_en and FIFO non-empty
//  S_START | start bit (tx=0) for CLKS_PER_BIT cycles
//  S_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
//  S_STOP  | stop bit (tx=1) for CLKS_PER_BIT cycles, then back to idle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             cnt_tc;

    // Bit timer is a down-counter; the last cycle of every bit is count zero.
    assign cnt_tc = (cnt == '0);

    // State, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shift <= shift_nxt;
        end
    end

    // Next-state logic and outputs, all decoded from the current state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        fifo_pop  = 1'b0;
        tx        = 1'b1;
        busy      = 1'b0;

        case (state)
            S_IDLE: begin
                // Gated with rst_n so no byte is consumed while held in reset.
                fifo_pop = rst_n & tx_en & ~fifo_empty;
                if (fifo_pop) begin
                    shift_nxt = fifo_rd_data;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = S_START;
                end
            end

            S_START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (cnt_tc) begin
                    cnt_nxt   = CNT_LOAD;
                    idx_nxt   = 3'd0;
                    state_nxt = S_DATA;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            S_DATA: begin
                tx   = shift[0];
                busy = 1'b1;
                if (cnt_tc) begin
                    cnt_nxt = CNT_LOAD;
                    if (idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        shift_nxt = shift >> 1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            S_STOP: begin
                busy = 1'b1;
                if (cnt_tc) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLKS_PER_BIT=4 and a small show-ahead FIFO model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_pop;
    logic       tx;
    logic       busy;

    // FIFO model: pushes from the stimulus, pops on the DUT strobe.
    logic [7:0] mem [0:15];
    logic [4:0] wr_ptr;
    logic [4:0] rd_ptr = '0;

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_rd_data = mem[rd_ptr[3:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_pop) rd_ptr <= rd_ptr + 5'd1;
    end

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_en        (tx_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_pop     (fifo_pop),
        .tx           (tx),
        .busy         (busy)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [9:0] frame;   // tx per bit slot, slot 0 (start) in the MSB
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int cyc, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, expv);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic idle_check(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk({name, " tx"}, c, tx, 1'b1);
            chk({name, " busy"}, c, busy, 1'b0);
            chk({name, " pop"}, c, fifo_pop, 1'b0);
        end
    endtask

    // Called at a negedge; returns just after the negedge of the pop cycle.
    task automatic wait_pop(input string name, input int budget, output int waited);
        waited = 0;
        #1;
        while (fifo_pop !== 1'b1 && waited < budget) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (fifo_pop !== 1'b1) begin
            errors++;
            $display("FAIL %s pop timeout: fifo_pop=%b after %0d cycles, expected 1", name, fifo_pop, waited);
        end
    endtask

    // Checks cycles T+1..T+ncyc of a frame; a full frame also checks T+41.
    task automatic check_frame(input string name, input logic [9:0] exp, input int ncyc,
                               input int drop_at, input logic next_pop);
        int slot;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            slot = (c - 1) / CPB;
            chk({name, " tx"}, c, tx, exp[9 - slot]);
            chk({name, " busy"}, c, busy, 1'b1);
            chk({name, " pop"}, c, fifo_pop, 1'b0);
            if (c == drop_at) tx_en = 1'b0;
        end
        if (ncyc == 10 * CPB) begin
            @(negedge clk);
            chk({name, " gap tx"}, ncyc + 1, tx, 1'b1);
            chk({name, " gap busy"}, ncyc + 1, busy, 1'b0);
            chk({name, " gap pop"}, ncyc + 1, fifo_pop, next_pop);
        end
    endtask

    initial begin
        int waited;

        vecs[0] = '{name: "v_a5", data: 8'hA5, frame: 10'b0101001011};
        vecs[1] = '{name: "v_01", data: 8'h01, frame: 10'b0100000001};
        vecs[2] = '{name: "v_80", data: 8'h80, frame: 10'b0000000011};
        vecs[3] = '{name: "v_55", data: 8'h55, frame: 10'b0101010101};
        vecs[4] = '{name: "v_3c", data: 8'h3C, frame: 10'b0001111001};
        vecs[5] = '{name: "v_81", data: 8'h81, frame: 10'b0100000011};

        wr_ptr = '0;
        rst_n  = 1'b0;
        tx_en  = 1'b1;

        // Reset held with a non-empty FIFO and tx_en high.
        push(vecs[0].data);
        idle_check("reset", 3);
        rst_n = 1'b1;

        // Table of single frames, each sent from an otherwise empty FIFO.
        for (int i = 0; i < 6; i++) begin
            if (i > 0) push(vecs[i].data);
            wait_pop(vecs[i].name, 20, waited);
            check_frame(vecs[i].name, vecs[i].frame, 10 * CPB, 0, 1'b0);
        end

        // Back-to-back frames: second pop lands in the single idle-high cycle.
        push(8'h00);
        push(8'hFF);
        wait_pop("b2b", 20, waited);
        check_frame("b2b_00", 10'b0000000001, 10 * CPB, 0, 1'b1);
        check_frame("b2b_ff", 10'b0111111111, 10 * CPB, 0, 1'b0);

        // tx_en dropped mid-frame: frame completes, no further pop until re-enabled.
        push(8'h3C);
        push(8'h55);
        wait_pop("gate", 20, waited);
        check_frame("gate_3c", 10'b0001111001, 10 * CPB, 10, 1'b0);
        idle_check("gate_hold", 8);
        tx_en = 1'b1;
        wait_pop("gate_resume", 3, waited);
        chk("gate_resume_immediate", waited, (waited == 0), 1'b1);
        check_frame("gate_55", 10'b0101010101, 10 * CPB, 0, 1'b0);

        // Reset at T+15 of an 0x81 frame; the next frame carries the new head.
        push(8'h81);
        push(8'h5A);
        wait_pop("rst", 20, waited);
        check_frame("rst_81", 10'b0100000011, 15, 0, 1'b0);
        rst_n = 1'b0;
        tx_en = 1'b0;
        @(negedge clk);
        chk("rst_after tx", 16, tx, 1'b1);
        chk("rst_after busy", 16, busy, 1'b0);
        chk("rst_after pop", 16, fifo_pop, 1'b0);
        rst_n = 1'b1;
        idle_check("rst_hold", 5);
        tx_en = 1'b1;
        wait_pop("rst_resume", 3, waited);
        chk("rst_resume_immediate", waited, (waited == 0), 1'b1);
        check_frame("rst_next_5a", 10'b0010110101, 10 * CPB, 0, 1'b0);

        // Empty FIFO with tx_en high, then a byte arrives while idle.
        idle_check("empty", 100);
        push(8'hC3);
        wait_pop("arrive", 3, waited);
        chk("arrive_immediate", waited, (waited == 0), 1'b1);
        check_frame("arrive_c3", 10'b0110000111, 10 * CPB, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
